// File: rtl/controlador_tablero_pkg.sv
// rtl/controlador_tablero_pkg.sv - cell encodings, state type and board size for the board owner
package controlador_tablero_pkg;

    localparam logic [1:0] EMPTY      = 2'b00;
    localparam logic [1:0] P1         = 2'b01;
    localparam logic [1:0] P2         = 2'b10;
    localparam int         BOARD_SIZE = 9;

    typedef logic [1:0] cell_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    function automatic cell_t other_player(input cell_t p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/controlador_tablero_if.sv
// rtl/controlador_tablero_if.sv - move request/response handshake between a player source and the board owner
interface controlador_tablero_if;

    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       move_ack;
    logic       move_err;

    modport master (
        output move_valid,
        output move_pos,
        input  move_ready,
        input  move_ack,
        input  move_err
    );

    modport slave (
        input  move_valid,
        input  move_pos,
        output move_ready,
        output move_ack,
        output move_err
    );

endinterface

// File: rtl/controlador_tablero.sv
// rtl/controlador_tablero.sv - validates moves, writes the nine cells, alternates turns and declares game end
module controlador_tablero
    import controlador_tablero_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = P1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_game,
    controlador_tablero_if.slave  mv,
    input  logic                  winner,
    input  logic [1:0]            winner_player,
    output logic [1:0]            pos1,
    output logic [1:0]            pos2,
    output logic [1:0]            pos3,
    output logic [1:0]            pos4,
    output logic [1:0]            pos5,
    output logic [1:0]            pos6,
    output logic [1:0]            pos7,
    output logic [1:0]            pos8,
    output logic [1:0]            pos9,
    output logic [1:0]            turn,
    output logic                  game_over,
    output logic                  draw,
    output logic [1:0]            result_player,
    output logic [3:0]            move_count
);

    state_t state;
    cell_t  board [BOARD_SIZE];
    logic   ack_q;
    logic   err_q;
    logic   legal;

    // Only an in-range index that addresses an empty cell can match here.
    always_comb begin
        legal = 1'b0;
        for (int i = 0; i < BOARD_SIZE; i++) begin
            if (mv.move_pos == 4'(i + 1) && board[i] == EMPTY) begin
                legal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= PLAY;
            for (int i = 0; i < BOARD_SIZE; i++) board[i] <= EMPTY;
            turn          <= FIRST_PLAYER;
            move_count    <= 4'd0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            game_over     <= 1'b0;
            draw          <= 1'b0;
            result_player <= EMPTY;
        end else if (new_game) begin
            state         <= PLAY;
            for (int i = 0; i < BOARD_SIZE; i++) board[i] <= EMPTY;
            turn          <= FIRST_PLAYER;
            move_count    <= 4'd0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            game_over     <= 1'b0;
            draw          <= 1'b0;
            result_player <= EMPTY;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                PLAY: begin
                    if (mv.move_valid) begin
                        if (legal) begin
                            for (int i = 0; i < BOARD_SIZE; i++) begin
                                if (mv.move_pos == 4'(i + 1)) board[i] <= turn;
                            end
                            move_count <= move_count + 4'd1;
                            ack_q      <= 1'b1;
                            state      <= CHECK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // Detector already sees the new cell; a win outranks a full board.
                CHECK: begin
                    if (winner) begin
                        result_player <= winner_player;
                        game_over     <= 1'b1;
                        state         <= OVER;
                    end else if (move_count == 4'(BOARD_SIZE)) begin
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        turn  <= other_player(turn);
                        state <= PLAY;
                    end
                end
                OVER:    ;
                default: state <= PLAY;
            endcase
        end
    end

    assign mv.move_ready = (state == PLAY);
    assign mv.move_ack   = ack_q;
    assign mv.move_err   = err_q;

    assign pos1 = board[0];
    assign pos2 = board[1];
    assign pos3 = board[2];
    assign pos4 = board[3];
    assign pos5 = board[4];
    assign pos6 = board[5];
    assign pos7 = board[6];
    assign pos8 = board[7];
    assign pos9 = board[8];

endmodule

// File: tb/tb_controlador_tablero.sv
// tb/tb_controlador_tablero.sv - self-checking bench for controlador_tablero
module tb_controlador_tablero;
    import controlador_tablero_pkg::*;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic new_game = 1'b0;
    always #5 clk = ~clk;

    controlador_tablero_if mif ();
    controlador_tablero_if mif2 ();

    logic [8:0][1:0] pa, pb, mb;
    logic            win_a, win_b;
    logic [1:0]      wp_a, wp_b;
    logic [1:0]      turn_a, turn_b, res_a, res_b;
    logic            over_a, over_b, draw_a, draw_b;
    logic [3:0]      cnt_a, cnt_b;

    logic [1:0] mt;
    logic [3:0] mc;
    logic       exp_q [$];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ng;
        logic [3:0] pos;
        logic       ack;
        logic [3:0] cnt;
        logic [1:0] trn;
        logic       ovr;
        logic       drw;
        logic [1:0] res;
    } vec_t;
    vec_t vt [$];

    // Reference win detector, the sibling the board owner is wired to in the game top.
    function automatic logic [2:0] detect(input logic [8:0][1:0] b);
        int ln [8][3];
        logic [2:0] r;
        ln = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        r = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (b[ln[i][0]] != 2'b00 && b[ln[i][0]] == b[ln[i][1]] && b[ln[i][1]] == b[ln[i][2]])
                r = {1'b1, b[ln[i][0]]};
        end
        return r;
    endfunction

    always_comb {win_a, wp_a} = detect(pa);
    always_comb {win_b, wp_b} = detect(pb);

    controlador_tablero dut_a (
        .clk(clk), .reset(reset), .new_game(new_game), .mv(mif),
        .winner(win_a), .winner_player(wp_a),
        .pos1(pa[0]), .pos2(pa[1]), .pos3(pa[2]), .pos4(pa[3]), .pos5(pa[4]),
        .pos6(pa[5]), .pos7(pa[6]), .pos8(pa[7]), .pos9(pa[8]),
        .turn(turn_a), .game_over(over_a), .draw(draw_a),
        .result_player(res_a), .move_count(cnt_a)
    );

    controlador_tablero #(.FIRST_PLAYER(P2)) dut_b (
        .clk(clk), .reset(reset), .new_game(new_game), .mv(mif2),
        .winner(win_b), .winner_player(wp_b),
        .pos1(pb[0]), .pos2(pb[1]), .pos3(pb[2]), .pos4(pb[3]), .pos5(pb[4]),
        .pos6(pb[5]), .pos7(pb[6]), .pos8(pb[7]), .pos9(pb[8]),
        .turn(turn_b), .game_over(over_b), .draw(draw_b),
        .result_player(res_b), .move_count(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted attempt pushed one expectation (1 = ack, 0 = err).
    always @(negedge clk) begin
        logic e;
        if (mif.move_ack || mif.move_err) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp", {30'b0, mif.move_ack, mif.move_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_ack_err", {30'b0, mif.move_ack, mif.move_err}, e ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic add(input logic ng, input int pos, input logic ack, input int cnt,
                       input int trn, input logic ovr, input logic drw, input int res);
        vec_t v;
        v.ng = ng; v.pos = 4'(pos); v.ack = ack; v.cnt = 4'(cnt);
        v.trn = 2'(trn); v.ovr = ovr; v.drw = drw; v.res = 2'(res);
        vt.push_back(v);
    endtask

    task automatic model_clear();
        mb = '0; mt = P1; mc = 4'd0;
    endtask

    task automatic start_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!mif.move_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!mif.move_ready) chk("ready_timeout", {31'b0, mif.move_ready}, 32'd1);
    endtask

    task automatic do_move(input logic [3:0] p, input logic exp_ack);
        logic [2:0] d;
        wait_ready();
        mif.move_valid = 1'b1;
        mif.move_pos   = p;
        exp_q.push_back(exp_ack);
        @(negedge clk);
        mif.move_valid = 1'b0;
        if (exp_ack) begin
            mb[p - 4'd1] = mt;
            mc = mc + 4'd1;
            @(negedge clk);
            d = detect(mb);
            if (!d[2] && mc != 4'd9) mt = other_player(mt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.move_valid = 1'b0; mif.move_pos = 4'd0;
        mif2.move_valid = 1'b0; mif2.move_pos = 4'd0;

        // X row 1-2-3 win after reset
        add(0,1,1,1,2,0,0,0); add(0,4,1,2,1,0,0,0); add(0,2,1,3,2,0,0,0);
        add(0,5,1,4,1,0,0,0); add(0,3,1,5,1,1,0,1);
        // occupied cell
        add(1,5,1,1,2,0,0,0); add(0,5,0,1,2,0,0,0);
        // out-of-range indices
        add(1,0,0,0,1,0,0,0); add(0,12,0,0,1,0,0,0); add(0,10,0,0,1,0,0,0); add(0,15,0,0,1,0,0,0);
        // full board, no line
        add(1,1,1,1,2,0,0,0); add(0,2,1,2,1,0,0,0); add(0,3,1,3,2,0,0,0);
        add(0,5,1,4,1,0,0,0); add(0,4,1,5,2,0,0,0); add(0,6,1,6,1,0,0,0);
        add(0,8,1,7,2,0,0,0); add(0,7,1,8,1,0,0,0); add(0,9,1,9,1,1,1,0);
        // win on the ninth move
        add(1,1,1,1,2,0,0,0); add(0,2,1,2,1,0,0,0); add(0,3,1,3,2,0,0,0);
        add(0,4,1,4,1,0,0,0); add(0,6,1,5,2,0,0,0); add(0,5,1,6,1,0,0,0);
        add(0,8,1,7,2,0,0,0); add(0,7,1,8,1,0,0,0); add(0,9,1,9,1,1,0,1);

        repeat (2) @(negedge clk);
        chk("rst_board", pa, 32'd0);
        chk("rst_turn", turn_a, P1);
        chk("rst_turn_p2first", turn_b, P2);
        chk("rst_count", cnt_a, 32'd0);
        chk("rst_ready", mif.move_ready, 32'd1);
        chk("rst_ack_err", {mif.move_ack, mif.move_err}, 32'd0);
        chk("rst_over_draw", {over_a, draw_a}, 32'd0);
        chk("rst_result", res_a, 32'd0);
        reset = 1'b0;
        model_clear();

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].ng) start_game();
            do_move(vt[i].pos, vt[i].ack);
            chk($sformatf("v%0d_count", i), cnt_a, vt[i].cnt);
            chk($sformatf("v%0d_turn", i), turn_a, vt[i].trn);
            chk($sformatf("v%0d_game_over", i), over_a, vt[i].ovr);
            chk($sformatf("v%0d_draw", i), draw_a, vt[i].drw);
            chk($sformatf("v%0d_result", i), res_a, vt[i].res);
            chk($sformatf("v%0d_board", i), pa, mb);
        end

        // move_valid held through CHECK is ignored
        start_game();
        wait_ready();
        mif.move_valid = 1'b1; mif.move_pos = 4'd1;
        exp_q.push_back(1'b1);
        @(negedge clk);
        mif.move_pos = 4'd2;
        chk("check_ready", mif.move_ready, 32'd0);
        @(negedge clk);
        mif.move_valid = 1'b0;
        mb[0] = P1; mc = 4'd1; mt = P2;
        chk("check_board", pa, mb);
        chk("check_count", cnt_a, 32'd1);
        chk("check_turn", turn_a, P2);
        chk("check_ready_back", mif.move_ready, 32'd1);

        // requests ignored in OVER, then new_game clears
        start_game();
        do_move(4'd1, 1'b1); do_move(4'd4, 1'b1); do_move(4'd2, 1'b1);
        do_move(4'd5, 1'b1); do_move(4'd3, 1'b1);
        chk("over_level", over_a, 32'd1);
        mif.move_valid = 1'b1; mif.move_pos = 4'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("over_ready%0d", i), mif.move_ready, 32'd0);
        end
        mif.move_valid = 1'b0;
        chk("over_board", pa, mb);
        chk("over_count", cnt_a, 32'd5);
        start_game();
        chk("ng_board", pa, 32'd0);
        chk("ng_turn", turn_a, P1);
        chk("ng_over", over_a, 32'd0);
        chk("ng_result", res_a, 32'd0);
        chk("ng_count", cnt_a, 32'd0);
        chk("ng_ready", mif.move_ready, 32'd1);
        chk("ng_turn_p2first", turn_b, P2);

        // new_game together with an attempt discards the attempt
        new_game = 1'b1; mif.move_valid = 1'b1; mif.move_pos = 4'd1;
        @(negedge clk);
        new_game = 1'b0; mif.move_valid = 1'b0;
        @(negedge clk);
        chk("ngmove_board", pa, 32'd0);
        chk("ngmove_count", cnt_a, 32'd0);

        // async reset asserted mid-cycle while in CHECK
        wait_ready();
        mif.move_valid = 1'b1; mif.move_pos = 4'd5;
        exp_q.push_back(1'b1);
        @(negedge clk);
        mif.move_valid = 1'b0;
        mb[4] = P1;
        chk("arst_pre_ready", mif.move_ready, 32'd0);
        chk("arst_pre_board", pa, mb);
        #2 reset = 1'b1;
        #1;
        chk("arst_board", pa, 32'd0);
        chk("arst_count", cnt_a, 32'd0);
        chk("arst_turn", turn_a, P1);
        chk("arst_ready", mif.move_ready, 32'd1);
        chk("arst_ack", mif.move_ack, 32'd0);
        chk("arst_turn_p2first", turn_b, P2);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        do_move(4'd9, 1'b1);
        chk("post_rst_board", pa, mb);
        chk("post_rst_turn", turn_a, P2);

        repeat (2) @(negedge clk);
        chk("pending_resp", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
